// File: rtl/imem_uart_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_uart_loader_pkg
// Shared definitions for the UART boot loader: loader FSM state encoding,
// default frame start marker and frame field widths.
// ---------------------------------------------------------------------------
package imem_uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
    localparam int         BYTE_W            = 8;
    localparam int         WORD_W            = 16;
    localparam int         LEN_W             = 16;   // word count field, big-endian

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } loader_state_e;

endpackage

// File: rtl/imem_uart_loader_if.sv
// ---------------------------------------------------------------------------
// imem_uart_loader_if
// Instruction RAM write port bundle driven by the boot loader.
//   w_addr : word address
//   din    : 16-bit write data
//   w_en   : one-cycle write strobe per word
// Modports: master (loader side), slave (RAM side).
// ---------------------------------------------------------------------------
interface imem_uart_loader_if
    import imem_uart_loader_pkg::*;
#(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] w_addr;
    logic [WORD_W-1:0] din;
    logic              w_en;

    modport master (output w_addr, output din, output w_en);
    modport slave  (input  w_addr, input  din, input  w_en);
endinterface

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver, LSB first, idle high.
//   clk, reset : system clock, synchronous active-high reset
//   rx         : asynchronous serial input (2-flop synchronised here)
//   data       : last received byte, valid while byte_valid is high
//   byte_valid : one-cycle pulse after a byte with a good stop bit
//   frame_err  : one-cycle pulse after a byte whose stop bit sampled low
// A falling edge is rechecked half a bit later; if the line is high again
// it was a glitch and the receiver returns to idle. After the stop-bit
// sample the receiver rearms immediately.
// ---------------------------------------------------------------------------
module uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [BYTE_W-1:0] data,
    output logic              byte_valid,
    output logic              frame_err
);
    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e         state_q, state_d;
    logic              rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[BYTE_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data       = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;
endmodule

// File: rtl/imem_uart_loader.sv
// ---------------------------------------------------------------------------
// imem_uart_loader
// UART boot loader for the instruction RAM write port. Receives the frame
//   SYNC_BYTE, LEN_HI, LEN_LO, N x {HI, LO} [, CSUM]
// writes each 16-bit word to i_ram and releases the CPU once the image is
// accepted.
//   clk, reset : system clock, synchronous active-high reset
//   rx         : UART input (idle high, 8N1)
//   wr         : i_ram write port (w_addr, din, w_en), master side
//   cpu_hold   : high keeps the CPU in reset
//   done       : image accepted, sticky until reset
//   error      : last frame rejected, cleared by the next SYNC_BYTE
// Build option LOADER_CHECKSUM_EN: when defined, a trailing CSUM byte (mod-256
// sum of LEN_HI, LEN_LO and all data bytes) is required and checked; when
// undefined the frame ends after the last word.
// ---------------------------------------------------------------------------
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          ADDR_W       = 12,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    imem_uart_loader_if.master  wr,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ferr;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    loader_state_e     state_q, state_d;
    logic [BYTE_W-1:0] len_hi_q, len_hi_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              w_en_q, w_en_d;
    logic              done_q, done_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              error_q, error_d;
    logic [LEN_W-1:0]  len_n;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= '0;
            hi_q       <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            w_addr_q   <= '0;
            din_q      <= '0;
            w_en_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            hi_q       <= hi_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            w_addr_q   <= w_addr_d;
            din_q      <= din_d;
            w_en_q     <= w_en_d;
            done_q     <= done_d;
            cpu_hold_q <= cpu_hold_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        hi_d       = hi_q;
        idx_d      = idx_q;
        last_d     = last_q;
        w_addr_d   = w_addr_q;
        din_d      = din_q;
        w_en_d     = 1'b0;
        done_d     = done_q;
        cpu_hold_d = cpu_hold_q;
        error_d    = error_q;
        len_n      = {len_hi_q, rx_data};

        // A broken stop bit aborts any frame in progress; idle and run ignore it.
        if (rx_ferr && !(state_q inside {ST_IDLE, ST_RUN, ST_ERR})) begin
            state_d = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        error_d = 1'b0;
                        state_d = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_valid) begin
                        len_hi_d = rx_data;
                        state_d  = ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_valid) begin
                        if ({16'd0, len_n} > MAX_WORDS) begin
                            state_d = ST_ERR;
                        end else if (len_n == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_RUN;
`endif
                        end else begin
                            idx_d   = '0;
                            // The bound check above keeps N-1 inside ADDR_W bits.
                            last_d  = ADDR_W'(len_n - LEN_W'(1));
                            state_d = ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (rx_valid) begin
                        hi_d    = rx_data;
                        state_d = ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (rx_valid) begin
                        din_d    = {hi_q, rx_data};
                        w_addr_d = idx_q;
                        w_en_d   = 1'b1;
                        idx_d    = idx_q + 1'b1;
                        if (idx_q == last_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_RUN;
`endif
                        end else begin
                            state_d = ST_DATA_HI;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == sum_q) begin
                            done_d     = 1'b1;
                            cpu_hold_d = 1'b0;
                            state_d    = ST_RUN;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    // Entering RUN from the last write delays done by a cycle,
                    // so done never coincides with w_en.
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
                ST_ERR: begin
                    error_d    = 1'b1;
                    cpu_hold_d = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef LOADER_CHECKSUM_EN
        sum_d = sum_q;
        if (state_q == ST_IDLE && rx_valid && rx_data == SYNC_BYTE)
            sum_d = '0;
        else if (rx_valid && state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO})
            sum_d = sum_q + rx_data;
`endif
    end

    assign wr.w_addr = w_addr_q;
    assign wr.din    = din_q;
    assign wr.w_en   = w_en_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_uart_loader
// Directed bench for imem_uart_loader. Serialises frames on rx, records every
// i_ram write and compares against hand-computed expectations. Works with and
// without LOADER_CHECKSUM_EN defined.
// Checksum byte = mod-256 sum of LEN_HI, LEN_LO and data bytes, e.g.
//   00+02+12+34+AB+CD = 0x1C0 -> C0 ;  00+01+BE+EF = 0x1AE -> AE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_uart_loader;
    localparam int CPB    = 16;
    localparam int ADDR_W = 12;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic cpu_hold, done, error;

    int checks   = 0;
    int failures = 0;

    imem_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_uart_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (ADDR_W),
        .SYNC_BYTE    (8'h55)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .wr       (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Write monitor: one entry {addr, data} per w_en pulse.
    logic [31:0] wr_log[$];
    int          bv_count = 0;
    logic        overlap  = 1'b0;

    always @(negedge clk) begin
        if (bus.w_en) begin
            wr_log.push_back(32'({bus.w_addr, bus.din}));
            $display("write addr=%0h din=%04h", bus.w_addr, bus.din);
            if (done) overlap = 1'b1;
        end
        if (dut.u_rx.byte_valid) bv_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 'x;
    endfunction

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        $display("tx byte=%02h stop=%0b", b, stop_bit);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_std_frame(input logic [7:0] csum);
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(csum,  1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wr_log.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_waddr"}, 32'(bus.w_addr), 32'h0);
        check({tag, "_din"},   32'(bus.din),    32'h0);
        check({tag, "_wen"},   32'(bus.w_en),   32'h0);
        check({tag, "_hold"},  32'(cpu_hold),   32'h1);
        check({tag, "_done"},  32'(done),       32'h0);
        check({tag, "_error"}, 32'(error),      32'h0);
    endtask

    initial begin
        int bv0;

        // Reset values.
        do_reset();
        check_reset_outputs("rst");

        // Good two-word image.
        send_std_frame(8'hC0);
        check("good_nwords", 32'(wr_log.size()), 32'd2);
        check("good_w0",     word_at(0), 32'h0000_1234);
        check("good_w1",     word_at(1), 32'h0001_ABCD);
        check("good_done",   32'(done),     32'h1);
        check("good_hold",   32'(cpu_hold), 32'h0);
        check("good_error",  32'(error),    32'h0);

        // Bad checksum, then the same frame with the right one.
        do_reset();
        send_std_frame(8'hC1);
        check("badcs_error", 32'(error),    32'(CS_EN));
        check("badcs_hold",  32'(cpu_hold), 32'(CS_EN));
        check("badcs_done",  32'(done),     32'(!CS_EN));
        send_std_frame(8'hC0);
        check("resend_done",   32'(done),  32'h1);
        check("resend_error",  32'(error), 32'h0);
        check("resend_nwords", 32'(wr_log.size()), CS_EN ? 32'd4 : 32'd2);

        // Leading garbage, then a zero-length image.
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("zero_nwords", 32'(wr_log.size()), 32'd0);
        check("zero_done",   32'(done),  32'h1);
        check("zero_error",  32'(error), 32'h0);

        // Length 4097 rejected; loader returns to IDLE and takes a new frame.
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h01, 1'b1);
        check("len_error",  32'(error),    32'h1);
        check("len_hold",   32'(cpu_hold), 32'h1);
        check("len_done",   32'(done),     32'h0);
        check("len_nwords", 32'(wr_log.size()), 32'd0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hAE, 1'b1);
        check("len_retry_w0",    word_at(0), 32'h0000_BEEF);
        check("len_retry_done",  32'(done),  32'h1);
        check("len_retry_error", 32'(error), 32'h0);

        // Framing error on the third data byte.
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        check("ferr_error",  32'(error),    32'h1);
        check("ferr_hold",   32'(cpu_hold), 32'h1);
        check("ferr_done",   32'(done),     32'h0);
        check("ferr_nwords", 32'(wr_log.size()), 32'd1);

        // Quarter-bit glitch in IDLE yields no byte; a real byte yields one.
        do_reset();
        bv0 = bv_count;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_bytes", 32'(bv_count - bv0), 32'd0);
        send_byte(8'h00, 1'b1);
        check("real_bytes", 32'(bv_count - bv0), 32'd1);

        // Reset between first and second word, then a fresh full load.
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("mid_nwords", 32'(wr_log.size()), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid");
        reset = 1'b0;
        wr_log.delete();
        @(negedge clk);
        send_std_frame(8'hC0);
        check("fresh_nwords", 32'(wr_log.size()), 32'd2);
        check("fresh_w0",     word_at(0), 32'h0000_1234);
        check("fresh_w1",     word_at(1), 32'h0001_ABCD);
        check("fresh_done",   32'(done),     32'h1);
        check("fresh_hold",   32'(cpu_hold), 32'h0);

        check("wen_done_overlap", 32'(overlap), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
